// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA coordinate type and default 640x480 timing
// Screen-bound constants shared by the scanner and the object blocks that consume its coordinates.
package vga_timing_pkg;

  typedef logic signed [10:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 2;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  localparam int H_TOTAL_DEF = h_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = v_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with wrap and sync/active decode
// The active/sync flags describe the value the counter holds after this cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step_i,
  output coord_t cnt_o,
  output logic   active_d_o,
  output logic   sync_n_d_o
);

  localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;

  coord_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      if (cnt_q == coord_t'(TOTAL - 1)) cnt_d = '0;
      else                              cnt_d = cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign active_d_o = (cnt_d < coord_t'(ACTIVE));
  assign sync_n_d_o = !((cnt_d >= coord_t'(SYNC_START)) && (cnt_d < coord_t'(SYNC_END)));

endmodule

// File: rtl/vga_pixel_scanner.sv
// rtl/vga_pixel_scanner.sv - raster timing source: coordinates, syncs, blanking, frame strobe
// Optional SOF_HALF_RATE_EN: startOfFrame only on frame events whose new frameCount is even.
module vga_pixel_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output coord_t     pixelX,
  output coord_t     pixelY,
  output logic       pixelEn,
  output logic       blankN,
  output logic       hSync,
  output logic       vSync,
  output logic       startOfFrame,
  output logic [7:0] frameCount
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick, v_step, frame_evt, sof_d;
  logic             h_active_d, v_active_d, h_sync_n_d, v_sync_n_d;
  logic [7:0]       frame_q, frame_d;
  logic             pix_en_q, blank_n_q, hsync_q, vsync_q, sof_q;

  assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .reset(reset), .step_i(tick),
    .cnt_o(pixelX), .active_d_o(h_active_d), .sync_n_d_o(h_sync_n_d)
  );

  assign v_step = tick && (pixelX == coord_t'(H_TOTAL - 1));

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .reset(reset), .step_i(v_step),
    .cnt_o(pixelY), .active_d_o(v_active_d), .sync_n_d_o(v_sync_n_d)
  );

  // Frame event fires on the tick that enters vertical blanking at (0, V_ACTIVE).
  assign frame_evt = v_step && (pixelY == coord_t'(V_ACTIVE - 1));
  assign frame_d   = frame_q + {7'd0, frame_evt};

`ifdef SOF_HALF_RATE_EN
  assign sof_d = frame_evt && !frame_d[0];
`else
  assign sof_d = frame_evt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      frame_q   <= '0;
      pix_en_q  <= 1'b0;
      blank_n_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      sof_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      frame_q  <= frame_d;
      pix_en_q <= tick;
      sof_q    <= sof_d;
      if (tick) begin
        blank_n_q <= h_active_d && v_active_d;
        hsync_q   <= h_sync_n_d;
        vsync_q   <= v_sync_n_d;
      end
    end
  end

  assign pixelEn      = pix_en_q;
  assign blankN       = blank_n_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign startOfFrame = sof_q;
  assign frameCount   = frame_q;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// tb/tb_vga_pixel_scanner.sv - self-checking bench for vga_pixel_scanner
// Three instances (small CLK_DIV=2, small CLK_DIV=1, default 640x480) checked every cycle against a count-based model.
module tb_vga_pixel_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  longint ka = 0, kb = 0, kc = 0;
  int checks = 0, failures = 0;

  logic [10:0] ax, ay, bx, by, cx, cy;
  logic ae, ab, ahs, avs, asf, be, bb, bhs, bvs, bsf, ce, cb, chs, cvs, csf;
  logic [7:0] afc, bfc, cfc;

  vga_pixel_scanner #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) u_a (
    .clk(clk), .reset(rst_a), .pixelX(ax), .pixelY(ay), .pixelEn(ae), .blankN(ab),
    .hSync(ahs), .vSync(avs), .startOfFrame(asf), .frameCount(afc));

  vga_pixel_scanner #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(rst_b), .pixelX(bx), .pixelY(by), .pixelEn(be), .blankN(bb),
    .hSync(bhs), .vSync(bvs), .startOfFrame(bsf), .frameCount(bfc));

  vga_pixel_scanner u_c (
    .clk(clk), .reset(rst_c), .pixelX(cx), .pixelY(cy), .pixelEn(ce), .blankN(cb),
    .hSync(chs), .vSync(cvs), .startOfFrame(csf), .frameCount(cfc));

  always @(posedge clk) begin
    ka <= rst_a ? 0 : ka + 1;
    kb <= rst_b ? 0 : kb + 1;
    kc <= rst_c ? 0 : kc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Everything follows from k = clocks since reset release: ticks = k/div, raster position = ticks mod frame.
  task automatic check_inst(input string nm, input int ha, input int hfp, input int hs, input int hbp,
                            input int va, input int vfp, input int vs, input int vbp, input int dv,
                            input longint k, input logic [10:0] x, input logic [10:0] y,
                            input logic en, input logic bl, input logic hsn, input logic vsn,
                            input logic sof, input logic [7:0] fc);
    longint ht, vt, ft, t, p, h, v, off, nfr;
    logic e_en, e_bl, e_hs, e_vs, e_sof;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    ft = ht * vt;
    t = k / dv;
    p = t % ft;
    h = p % ht;
    v = p / ht;
    off = va * ht;
    nfr = (t >= off) ? ((t - off) / ft + 1) : 0;
    e_en = (k > 0) && (k % dv == 0);
    e_sof = e_en && (p == off);
`ifdef SOF_HALF_RATE_EN
    e_sof = e_sof && (nfr % 2 == 0);
`endif
    if (t == 0) begin
      e_bl = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      e_bl = (h < ha) && (v < va);
      e_hs = !((h >= ha + hfp) && (h < ha + hfp + hs));
      e_vs = !((v >= va + vfp) && (v < va + vfp + vs));
    end
    chk({nm, ".pixelX"}, 32'(x), 32'(h));
    chk({nm, ".pixelY"}, 32'(y), 32'(v));
    chk({nm, ".pixelEn"}, 32'(en), 32'(e_en));
    chk({nm, ".blankN"}, 32'(bl), 32'(e_bl));
    chk({nm, ".hSync"}, 32'(hsn), 32'(e_hs));
    chk({nm, ".vSync"}, 32'(vsn), 32'(e_vs));
    chk({nm, ".startOfFrame"}, 32'(sof), 32'(e_sof));
    chk({nm, ".frameCount"}, 32'(fc), 32'(nfr % 256));
  endtask

  task automatic step();
    @(negedge clk);
    check_inst("a", 16, 2, 3, 3, 6, 1, 2, 1, 2, ka, ax, ay, ae, ab, ahs, avs, asf, afc);
    check_inst("b", 8, 1, 2, 1, 5, 1, 1, 1, 1, kb, bx, by, be, bb, bhs, bvs, bsf, bfc);
    check_inst("c", 640, 16, 96, 48, 480, 10, 2, 33, 2, kc, cx, cy, ce, cb, chs, cvs, csf, cfc);
  endtask

  initial begin
    int hold_a, gap_a, hold_c, gap_c, resets_a;
    logic [7:0] prev_bfc;
    logic wrap_seen;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (5) step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    hold_a = 0; gap_a = $urandom_range(900, 2500);
    hold_c = 0; gap_c = $urandom_range(4000, 9000);
    resets_a = 0;
    wrap_seen = 1'b0;
    prev_bfc = 8'd0;
    for (int cyc = 0; cyc < 26000; cyc++) begin
      step();
      if (prev_bfc == 8'd255 && bfc == 8'd0) wrap_seen = 1'b1;
      prev_bfc = bfc;
      if (hold_a > 0) begin
        hold_a--;
        if (hold_a == 0) rst_a = 1'b0;
      end else if (--gap_a == 0) begin
        rst_a = 1'b1;
        resets_a++;
        hold_a = $urandom_range(1, 4);
        gap_a = $urandom_range(200, 2500);
      end
      if (hold_c > 0) begin
        hold_c--;
        if (hold_c == 0) rst_c = 1'b0;
      end else if (--gap_c == 0) begin
        rst_c = 1'b1;
        hold_c = $urandom_range(1, 3);
        gap_c = $urandom_range(4000, 9000);
      end
    end
    chk("b.frameCount_wrap_seen", 32'(wrap_seen), 32'd1);
    chk("a.mid_frame_resets_applied", 32'(resets_a > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
